forwarding_hazard_ctrl: RTL and testbench
=========================================

Name: forwarding_hazard_ctrl

Overview:
- Controller for the two 3-input operand multiplexers in the EX stage (ALU operand A and operand B) of the 5-stage MIPS pipeline.
- Keeps its own shadow of destination-register information for the EX, MEM and WB stages, and drives both operand-mux selects.
- Detects load-use hazards and issues a one-cycle stall with bubble insertion.
- Handles branch flush and a global pipeline-enable freeze, used by the debug unit for step mode.

Parameters:
- NB_REG_ADDR, 5, width of register-file address fields.

Ports:
- clock_i, input, 1, system clock; all state updates on rising edge.
- reset_i, input, 1, synchronous active-high reset.
- enable_i, input, 1, pipeline advance enable; 0 freezes all internal state.
- valid_id_i, input, 1, an instruction is present in ID.
- rs_id_i, input, NB_REG_ADDR, rs field of the ID instruction.
- rt_id_i, input, NB_REG_ADDR, rt field of the ID instruction.
- use_rs_id_i, input, 1, the ID instruction reads rs.
- use_rt_id_i, input, 1, the ID instruction reads rt.
- rd_id_i, input, NB_REG_ADDR, final destination register of the ID instruction (already rt/rd/31 resolved).
- reg_write_id_i, input, 1, the ID instruction writes the register file.
- mem_read_id_i, input, 1, the ID instruction is a load.
- flush_i, input, 1, branch/jump taken; kill the instruction being moved into EX.
- fwd_a_sel_o, output, 2, operand A mux select: 00 register file, 01 MEM-stage result, 10 WB-stage result.
- fwd_b_sel_o, output, 2, operand B mux select, same encoding as fwd_a_sel_o.
- stall_o, output, 1, hold PC and the IF/ID register this cycle.

Behaviour:
- State: three slots, EX, MEM and WB. Each slot holds {valid, rd, reg_write, mem_read}. The EX slot also holds {rs, rt, use_rs, use_rt}.
- Reset (synchronous, takes priority over everything): all slot fields are 0. Outputs go to fwd_a_sel_o=00, fwd_b_sel_o=00, stall_o=0. A reset mid-stall clears the stall on the next edge.
- Load-use detect (combinational), hazard = valid_id_i & EX.valid & EX.mem_read & EX.reg_write & (EX.rd!=0) & ((use_rs_id_i & rs_id_i==EX.rd) | (use_rt_id_i & rt_id_i==EX.rd)).
- stall_o = hazard & enable_i & ~flush_i. A flush overrides the stall because the consumer is being killed anyway.
- On a clock edge with enable_i=1:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= bubble (all zero) if hazard or flush_i; otherwise EX <= the ID fields, with valid = valid_id_i.
- On a clock edge with enable_i=0 and no reset: all slots hold and stall_o=0.
- Forwarding select for operand A (combinational from the EX slot), first match wins:
  - If EX.valid & EX.use_rs & EX.rs!=0 & MEM.valid & MEM.reg_write & ~MEM.mem_read & MEM.rd==EX.rs, select 01.
  - Else if the same check against the WB slot (WB.mem_read allowed) matches, select 10.
  - Else select 00.
- Operand B uses the same rules with rt/use_rt.
- MEM has priority over WB because it holds the newer value.
- Register 0 is never forwarded.
- A load held in MEM is never a forward source. The load-use stall guarantees the consumer reaches EX only when the load is in WB.
- Select code 11 is never produced.
- Stall length: exactly 1 cycle per load-use pair. After the bubble the load sits in MEM, the hazard term deasserts, and the next edge moves the consumer into EX.
- Simultaneous hazard on rs and rt against the same load: still a single 1-cycle stall.
- Implementation is fully synchronous with no latches. Outputs are combinational from registered state plus the ID inputs.

Test Plan:
- Reset: assert reset_i for 2 cycles with arbitrary inputs -> fwd_a_sel_o=00, fwd_b_sel_o=00, stall_o=0. Reset while stall_o=1 -> stall_o=0 and all slots empty after the edge.
- EX-to-EX forward: issue add rd=8, then sub rs=8 rt=9 -> when sub is in EX, fwd_a_sel_o=01 and fwd_b_sel_o=00. Same sequence with rd=0 -> both selects 00.
- WB forward and priority:
  - Issue add rd=5, nop, then or rt=5 -> fwd_b_sel_o=10.
  - Issue add rd=5, add rd=5, then or rs=5 -> fwd_a_sel_o=01 (MEM wins).
- Load-use: issue lw rd=4, then add rs=4 rt=4 -> stall_o=1 for exactly 1 cycle, and EX holds a bubble in the following cycle. When add reaches EX, fwd_a_sel_o=10 and fwd_b_sel_o=10.
- Flush: lw rd=4 in EX, consumer in ID, flush_i=1 -> stall_o=0 and EX becomes a bubble. Separately, flush_i with no hazard -> the instruction entering EX produces no forwarding in later cycles.
- Freeze: hold enable_i=0 for 3 cycles mid-sequence -> selects are unchanged and stall_o=0. After release the sequence resumes exactly as if there had been no freeze.

Source files
------------

// File: rtl/forwarding_hazard_ctrl_if.sv
// forwarding_hazard_ctrl_if: ID-stage request, flush/enable controls and EX operand-mux/stall responses.
interface forwarding_hazard_ctrl_if #(parameter int NB_REG_ADDR = 5);
  logic                   enable_i;
  logic                   valid_id_i;
  logic [NB_REG_ADDR-1:0] rs_id_i;
  logic [NB_REG_ADDR-1:0] rt_id_i;
  logic                   use_rs_id_i;
  logic                   use_rt_id_i;
  logic [NB_REG_ADDR-1:0] rd_id_i;
  logic                   reg_write_id_i;
  logic                   mem_read_id_i;
  logic                   flush_i;
  logic [1:0]             fwd_a_sel_o;
  logic [1:0]             fwd_b_sel_o;
  logic                   stall_o;
  modport master (
    output enable_i, valid_id_i, rs_id_i, rt_id_i, use_rs_id_i, use_rt_id_i,
           rd_id_i, reg_write_id_i, mem_read_id_i, flush_i,
    input  fwd_a_sel_o, fwd_b_sel_o, stall_o
  );
  modport slave (
    input  enable_i, valid_id_i, rs_id_i, rt_id_i, use_rs_id_i, use_rt_id_i,
           rd_id_i, reg_write_id_i, mem_read_id_i, flush_i,
    output fwd_a_sel_o, fwd_b_sel_o, stall_o
  );
endinterface

// File: rtl/forwarding_hazard_ctrl.sv
// forwarding_hazard_ctrl: EX operand forwarding selects, load-use stall and flush/freeze for a 5-stage MIPS pipe.
module forwarding_hazard_ctrl #(
  parameter int NB_REG_ADDR = 5
) (
  input logic                    clock_i,
  input logic                    reset_i,
  forwarding_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic                   valid;
    logic [NB_REG_ADDR-1:0] rd;
    logic                   reg_write;
    logic                   mem_read;
  } slot_t;
  typedef struct packed {
    slot_t                  s;
    logic [NB_REG_ADDR-1:0] rs;
    logic [NB_REG_ADDR-1:0] rt;
    logic                   use_rs;
    logic                   use_rt;
  } ex_t;
  ex_t   ex_q, ex_d, id_ex;
  slot_t mem_q, mem_d, wb_q, wb_d;
  logic  hazard;
  // A load in MEM is never a source; the load-use stall guarantees it is in WB when needed.
  function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic use_r,
                                         input logic [NB_REG_ADDR-1:0] r,
                                         input slot_t mem, input slot_t wb);
    logic ok, mem_hit, wb_hit;
    ok      = ex_valid & use_r & (r != '0);
    mem_hit = mem.valid & mem.reg_write & ~mem.mem_read & (mem.rd == r);
    wb_hit  = wb.valid & wb.reg_write & (wb.rd == r);
    return (ok & mem_hit) ? 2'b01 : (ok & wb_hit) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    hazard = bus.valid_id_i & ex_q.s.valid & ex_q.s.mem_read & ex_q.s.reg_write & (ex_q.s.rd != '0) &
             ((bus.use_rs_id_i & (bus.rs_id_i == ex_q.s.rd)) | (bus.use_rt_id_i & (bus.rt_id_i == ex_q.s.rd)));
    id_ex.s.valid     = bus.valid_id_i;
    id_ex.s.rd        = bus.rd_id_i;
    id_ex.s.reg_write = bus.reg_write_id_i;
    id_ex.s.mem_read  = bus.mem_read_id_i;
    id_ex.rs          = bus.rs_id_i;
    id_ex.rt          = bus.rt_id_i;
    id_ex.use_rs      = bus.use_rs_id_i;
    id_ex.use_rt      = bus.use_rt_id_i;
    ex_d  = bus.enable_i ? ((hazard | bus.flush_i) ? '0 : id_ex) : ex_q;
    mem_d = bus.enable_i ? ex_q.s : mem_q;
    wb_d  = bus.enable_i ? mem_q : wb_q;
  end
  assign bus.stall_o     = hazard & bus.enable_i & ~bus.flush_i;
  assign bus.fwd_a_sel_o = fwd_sel(ex_q.s.valid, ex_q.use_rs, ex_q.rs, mem_q, wb_q);
  assign bus.fwd_b_sel_o = fwd_sel(ex_q.s.valid, ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end
endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// tb_forwarding_hazard_ctrl: directed scenarios plus randomized traffic against an instruction-level pipeline model.
module tb_forwarding_hazard_ctrl;
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
  } ins_t;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  ins_t id, pipe[3];
  bit   en, fl;
  forwarding_hazard_ctrl_if #(.NB_REG_ADDR(5)) bus ();
  forwarding_hazard_ctrl #(.NB_REG_ADDR(5)) dut (.clock_i(clk), .reset_i(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic ins_t mk(bit v, bit [4:0] rd, bit rw, bit mr, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt);
    ins_t i;
    i.v = v; i.rd = rd; i.rw = rw; i.mr = mr; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    return i;
  endfunction
  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  // Model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, each an instruction record.
  function automatic bit exp_hazard();
    ins_t e = pipe[0];
    return id.v && e.v && e.mr && e.rw && e.rd != 0 &&
           ((id.urs && id.rs == e.rd) || (id.urt && id.rt == e.rd));
  endfunction
  function automatic bit exp_stall();
    return exp_hazard() && en && !fl;
  endfunction
  function automatic bit [1:0] exp_sel(bit opa);
    bit [4:0] r = opa ? pipe[0].rs : pipe[0].rt;
    bit       u = opa ? pipe[0].urs : pipe[0].urt;
    if (!pipe[0].v || !u || r == 0) return 2'd0;
    if (pipe[1].v && pipe[1].rw && !pipe[1].mr && pipe[1].rd == r) return 2'd1;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd == r) return 2'd2;
    return 2'd0;
  endfunction
  task automatic apply();
    bus.enable_i = en; bus.flush_i = fl;
    bus.valid_id_i = id.v; bus.rd_id_i = id.rd; bus.reg_write_id_i = id.rw; bus.mem_read_id_i = id.mr;
    bus.rs_id_i = id.rs; bus.rt_id_i = id.rt; bus.use_rs_id_i = id.urs; bus.use_rt_id_i = id.urt;
    #1;
  endtask
  task automatic tick();
    bit kill = exp_hazard() || fl;
    @(posedge clk);
    if (rst) begin
      foreach (pipe[k]) pipe[k] = nop();
    end else if (en) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = kill ? nop() : id;
    end
    #1;
  endtask
  task automatic do_reset();
    rst = 1; en = 1; fl = 0; id = nop();
    apply(); tick(); rst = 0; apply();
  endtask
  task automatic test_reset();
    rst = 1; en = 1; fl = 0;
    for (int c = 0; c < 2; c++) begin
      id = mk(1, 5'($urandom), 1, 1, 5'($urandom), 5'($urandom), 1, 1);
      apply(); tick(); apply();
      vectors++;
      if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o, bus.stall_o} !== 5'b0) begin
        miscompares++; $display("FAIL reset_outputs got %b want 00000", {bus.fwd_a_sel_o, bus.fwd_b_sel_o, bus.stall_o});
      end
    end
    rst = 0;
    id = mk(1, 4, 1, 1, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 6, 1, 0, 4, 4, 1, 1); apply();
    vectors++;
    if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL reset_prestall got %b want 1", bus.stall_o); end
    rst = 1; apply(); tick(); rst = 0; apply();
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL reset_midstall got %b want 0", bus.stall_o); end
  endtask
  task automatic test_ex_forward();
    do_reset();
    id = mk(1, 8, 1, 0, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 10, 1, 0, 8, 9, 1, 1); apply(); tick();
    id = nop(); apply();
    vectors++;
    if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o} !== 4'b0100) begin
      miscompares++; $display("FAIL ex_fwd got %b want 0100", {bus.fwd_a_sel_o, bus.fwd_b_sel_o});
    end
    do_reset();
    id = mk(1, 0, 1, 0, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 10, 1, 0, 0, 0, 1, 1); apply(); tick();
    id = nop(); apply();
    vectors++;
    if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o} !== 4'b0000) begin
      miscompares++; $display("FAIL ex_fwd_r0 got %b want 0000", {bus.fwd_a_sel_o, bus.fwd_b_sel_o});
    end
  endtask
  task automatic test_wb_forward();
    do_reset();
    id = mk(1, 5, 1, 0, 0, 0, 0, 0); apply(); tick();
    id = nop(); apply(); tick();
    id = mk(1, 7, 1, 0, 1, 5, 0, 1); apply(); tick();
    id = nop(); apply();
    vectors++;
    if (bus.fwd_b_sel_o !== 2'b10) begin miscompares++; $display("FAIL wb_fwd got %b want 10", bus.fwd_b_sel_o); end
    do_reset();
    id = mk(1, 5, 1, 0, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 5, 1, 0, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 7, 1, 0, 5, 0, 1, 0); apply(); tick();
    id = nop(); apply();
    vectors++;
    if (bus.fwd_a_sel_o !== 2'b01) begin miscompares++; $display("FAIL mem_priority got %b want 01", bus.fwd_a_sel_o); end
  endtask
  task automatic test_load_use();
    do_reset();
    id = mk(1, 4, 1, 1, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 6, 1, 0, 4, 4, 1, 1); apply();
    vectors++;
    if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %b want 1", bus.stall_o); end
    tick(); apply();
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL lu_stall_len got %b want 0", bus.stall_o); end
    vectors++;
    if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o} !== 4'b0000) begin
      miscompares++; $display("FAIL lu_bubble got %b want 0000", {bus.fwd_a_sel_o, bus.fwd_b_sel_o});
    end
    tick(); id = nop(); apply();
    vectors++;
    if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o} !== 4'b1010) begin
      miscompares++; $display("FAIL lu_fwd got %b want 1010", {bus.fwd_a_sel_o, bus.fwd_b_sel_o});
    end
  endtask
  task automatic test_flush();
    do_reset();
    id = mk(1, 4, 1, 1, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 6, 1, 0, 4, 0, 1, 0); fl = 1; apply();
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b want 0", bus.stall_o); end
    tick(); fl = 0; id = mk(1, 9, 1, 0, 4, 0, 1, 0); apply();
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL flush_bubble got %b want 0", bus.stall_o); end
    do_reset();
    id = mk(1, 7, 1, 0, 0, 0, 0, 0); fl = 1; apply(); tick();
    fl = 0; id = mk(1, 9, 1, 0, 7, 7, 1, 1); apply(); tick();
    id = nop(); apply();
    vectors++;
    if ({bus.fwd_a_sel_o, bus.fwd_b_sel_o} !== 4'b0000) begin
      miscompares++; $display("FAIL flush_nofwd got %b want 0000", {bus.fwd_a_sel_o, bus.fwd_b_sel_o});
    end
  endtask
  task automatic test_freeze();
    do_reset();
    id = mk(1, 5, 1, 0, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 7, 1, 0, 5, 0, 1, 0); apply(); tick();
    en = 0;
    for (int c = 0; c < 3; c++) begin
      id = mk(1, 5'($urandom), 1, 1, 5'($urandom), 5'($urandom), 1, 1); apply(); tick(); apply();
      vectors++;
      if ({bus.fwd_a_sel_o, bus.stall_o} !== 3'b010) begin
        miscompares++; $display("FAIL freeze_hold got %b want 010", {bus.fwd_a_sel_o, bus.stall_o});
      end
    end
    en = 1; id = nop(); apply(); tick(); tick(); apply();
    vectors++;
    if (bus.fwd_a_sel_o !== 2'b00) begin miscompares++; $display("FAIL freeze_resume got %b want 00", bus.fwd_a_sel_o); end
    do_reset();
    id = mk(1, 4, 1, 1, 0, 0, 0, 0); apply(); tick();
    id = mk(1, 6, 1, 0, 0, 4, 0, 1); en = 0; apply();
    vectors++;
    if (bus.stall_o !== 1'b0) begin miscompares++; $display("FAIL freeze_nostall got %b want 0", bus.stall_o); end
    tick(); tick(); en = 1; apply();
    vectors++;
    if (bus.stall_o !== 1'b1) begin miscompares++; $display("FAIL freeze_release got %b want 1", bus.stall_o); end
  endtask
  task automatic test_random();
    bit held = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      if (!held) id = mk($urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 2) == 0,
                         5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      apply();
      vectors++;
      if (bus.stall_o !== exp_stall()) begin
        miscompares++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, bus.stall_o, exp_stall());
      end
      vectors++;
      if (bus.fwd_a_sel_o !== exp_sel(1)) begin
        miscompares++; $display("FAIL rnd_fwd_a cyc %0d got %b want %b", c, bus.fwd_a_sel_o, exp_sel(1));
      end
      vectors++;
      if (bus.fwd_b_sel_o !== exp_sel(0)) begin
        miscompares++; $display("FAIL rnd_fwd_b cyc %0d got %b want %b", c, bus.fwd_b_sel_o, exp_sel(0));
      end
      held = (exp_stall() && !rst) || !en;
      tick();
    end
    rst = 0;
  endtask
  initial begin
    rst = 1; en = 1; fl = 0; id = nop();
    foreach (pipe[k]) pipe[k] = nop();
    apply();
    test_reset();
    test_ex_forward();
    test_wb_forward();
    test_load_use();
    test_flush();
    test_freeze();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
